// File: rtl/me_ref_row_feeder_if.sv
// Controller/reference-buffer/PE-array bundle for the reference row feeder.
// The feeder takes the slave side; the environment (controller + buffer) is the master.
interface me_ref_row_feeder_if #(
    parameter int PIX_W   = 8,
    parameter int ROW_PIX = 32,
    parameter int ADDR_W  = 11
);
    localparam int ROW_W = PIX_W * ROW_PIX;

    logic              start;
    logic              ref_input_control;
    logic              change_ref;
    logic              CB_select;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [ROW_W-1:0]  mem_rdata;
    logic [ROW_W-1:0]  ref_row;
    logic              ref_valid;
    logic [4:0]        col_idx;
    logic              pass_id;
    logic              col_done;
    logic              pass_err;
    logic              busy;
    logic              done;

    modport slave (
        input  start, ref_input_control, change_ref, CB_select, mem_rdata,
        output mem_rd_en, mem_addr, ref_row, ref_valid, col_idx, pass_id,
               col_done, pass_err, busy, done
    );

    modport master (
        output start, ref_input_control, change_ref, CB_select, mem_rdata,
        input  mem_rd_en, mem_addr, ref_row, ref_valid, col_idx, pass_id,
               col_done, pass_err, busy, done
    );
endinterface

// File: rtl/me_ref_row_feeder.sv
// Feeds reference rows to the PE array: one row per change_ref step, with a
// one-row prefetch so each step shows the next row after exactly one cycle.
module me_ref_row_feeder #(
    parameter int PIX_W         = 8,
    parameter int ROW_PIX       = 32,
    parameter int ROWS_PER_PASS = 38,
    parameter int NUM_COLS      = 32,
    parameter int ADDR_W        = 11
) (
    input  logic               clk,
    input  logic               rst,
    me_ref_row_feeder_if.slave bus
);
    localparam int ROW_W = PIX_W * ROW_PIX;
    localparam int RW    = $clog2(ROWS_PER_PASS);
    localparam int CW    = 5;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRIME0 = 3'd1;
    localparam logic [2:0] S_PRIME1 = 3'd2;
    localparam logic [2:0] S_FEED   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    typedef struct packed {
        logic [CW-1:0] col;
        logic          pass;
        logic [RW-1:0] row;
    } ptr_t;

    function automatic ptr_t advance(input ptr_t p);
        ptr_t n;
        n = p;
        if (p.row == RW'(ROWS_PER_PASS - 1)) begin
            n.row  = '0;
            n.pass = ~p.pass;
            if (p.pass) n.col = p.col + CW'(1);
        end else begin
            n.row = p.row + RW'(1);
        end
        return n;
    endfunction

    function automatic logic is_final(input ptr_t p);
        return (p.row == RW'(ROWS_PER_PASS - 1)) && p.pass && (p.col == CW'(NUM_COLS - 1));
    endfunction

    function automatic logic [ADDR_W-1:0] row_addr(input ptr_t p);
        return ADDR_W'(p.col) * ADDR_W'(ROWS_PER_PASS) + ADDR_W'(p.row);
    endfunction

    logic [2:0]       state_q, state_d;
    ptr_t             ptr_q, ptr_d;
    logic [ROW_W-1:0] ref_row_q, ref_row_d;
    logic [ROW_W-1:0] nxt_row_q, nxt_row_d;
    logic             ref_valid_q, ref_valid_d;
    logic             pend_q;
    logic             col_done_q, col_done_d;
    logic             pass_err_q, pass_err_d;
    logic             rd_en;
    ptr_t             rd_ptr;
    ptr_t             ptr_nxt;
    logic             step;

    assign step    = bus.change_ref & bus.ref_input_control;
    assign ptr_nxt = advance(ptr_q);

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ref_row_d   = ref_row_q;
        nxt_row_d   = nxt_row_q;
        ref_valid_d = ref_valid_q;
        col_done_d  = 1'b0;
        pass_err_d  = pass_err_q;
        rd_en       = 1'b0;
        rd_ptr      = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ptr_d      = '0;
                    pass_err_d = 1'b0;
                    rd_en      = 1'b1;
                    state_d    = S_PRIME0;
                end
            end
            S_PRIME0: begin
                ref_row_d = bus.mem_rdata;
                rd_en     = 1'b1;
                rd_ptr    = ptr_nxt;
                state_d   = S_PRIME1;
            end
            S_PRIME1: begin
                nxt_row_d   = bus.mem_rdata;
                ref_valid_d = 1'b1;
                state_d     = S_FEED;
            end
            S_FEED: begin
                if (step) begin
                    if (bus.CB_select == ptr_q.pass) pass_err_d = 1'b1;
                    // A prefetch still in flight is forwarded straight to the PE array.
                    ref_row_d = pend_q ? bus.mem_rdata : nxt_row_q;
                    if (ptr_q.pass && ptr_q.row == RW'(ROWS_PER_PASS - 1)) col_done_d = 1'b1;
                    if (is_final(ptr_q)) begin
                        ref_valid_d = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        ptr_d = ptr_nxt;
                        if (!is_final(ptr_nxt)) begin
                            rd_en  = 1'b1;
                            rd_ptr = advance(ptr_nxt);
                        end
                    end
                end else if (pend_q) begin
                    nxt_row_d = bus.mem_rdata;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the wide row registers are reset as well, because ref_row must read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            ref_row_q   <= '0;
            nxt_row_q   <= '0;
            ref_valid_q <= 1'b0;
            pend_q      <= 1'b0;
            col_done_q  <= 1'b0;
            pass_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ref_row_q   <= ref_row_d;
            nxt_row_q   <= nxt_row_d;
            ref_valid_q <= ref_valid_d;
            pend_q      <= rd_en;
            col_done_q  <= col_done_d;
            pass_err_q  <= pass_err_d;
        end
    end

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = row_addr(rd_ptr);
    assign bus.ref_row   = ref_row_q;
    assign bus.ref_valid = ref_valid_q;
    assign bus.col_idx   = ptr_q.col;
    assign bus.pass_id   = ptr_q.pass;
    assign bus.col_done  = col_done_q;
    assign bus.pass_err  = pass_err_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_me_ref_row_feeder.sv
// Randomized bench for me_ref_row_feeder against a linear row-index model of
// the search order, with an address-tagged reference buffer.
module tb_me_ref_row_feeder;
    localparam int PIX_W    = 8;
    localparam int ROW_PIX  = 32;
    localparam int ROWS     = 38;
    localparam int NCOLS    = 32;
    localparam int ADDR_W   = 11;
    localparam int W        = PIX_W * ROW_PIX;
    localparam int COL_ROWS = 2 * ROWS;
    localparam int TOTAL    = NCOLS * COL_ROWS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    me_ref_row_feeder_if #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .ADDR_W(ADDR_W)) fdr ();

    me_ref_row_feeder #(
        .PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .ROWS_PER_PASS(ROWS),
        .NUM_COLS(NCOLS), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(fdr)
    );

    function automatic logic [W-1:0] tag(input int a);
        logic [W-1:0] t;
        for (int i = 0; i < W / 32; i++) t[i*32 +: 32] = {a[15:0], 16'(a * 37 + i * 101)};
        return t;
    endfunction

    // Reference buffer: 1-cycle read latency, junk on cycles with no read.
    always @(posedge clk) begin
        if (fdr.mem_rd_en) fdr.mem_rdata <= tag(int'(fdr.mem_addr));
        else               fdr.mem_rdata <= {8{$urandom()}};
    end

    int n_tests = 0;
    int n_fail  = 0;
    int n_col_done = 0;
    int n_done  = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model: k is the linear position of the displayed row in the search order.
    bit m_busy, m_valid, m_ending, m_err, e_col_done, e_done;
    int m_prime, k;

    function automatic int k_pass(input int kk); return (kk % COL_ROWS) / ROWS; endfunction
    function automatic int k_col(input int kk);  return kk / COL_ROWS;          endfunction
    function automatic int k_addr(input int kk); return k_col(kk) * ROWS + kk % ROWS; endfunction
    function automatic logic exp_cb();            return k_pass(k) == 0;         endfunction

    task automatic model_clear();
        m_busy = 0; m_valid = 0; m_ending = 0; m_err = 0;
        e_col_done = 0; e_done = 0; m_prime = 0; k = 0;
    endtask

    task automatic model_edge();
        e_col_done = 0;
        e_done     = 0;
        if (!m_busy) begin
            if (fdr.start) begin
                m_busy = 1; m_prime = 2; k = 0; m_err = 0;
            end
        end else if (m_prime > 0) begin
            m_prime--;
            if (m_prime == 0) m_valid = 1;
        end else if (m_ending) begin
            m_busy = 0; m_ending = 0;
        end else if (fdr.change_ref && fdr.ref_input_control) begin
            if (fdr.CB_select != exp_cb()) m_err = 1;
            if (k % COL_ROWS == COL_ROWS - 1) e_col_done = 1;
            if (k == TOTAL - 1) begin
                m_valid = 0; m_ending = 1; e_done = 1;
            end else begin
                k++;
            end
        end
    endtask

    task automatic check_outputs();
        check("busy",      W'(fdr.busy),      W'(m_busy));
        check("ref_valid", W'(fdr.ref_valid), W'(m_valid));
        check("done",      W'(fdr.done),      W'(e_done));
        check("col_done",  W'(fdr.col_done),  W'(e_col_done));
        check("pass_err",  W'(fdr.pass_err),  W'(m_err));
        if (m_valid) begin
            check("ref_row", fdr.ref_row,       tag(k_addr(k)));
            check("col_idx", W'(fdr.col_idx),   W'(k_col(k)));
            check("pass_id", W'(fdr.pass_id),   W'(k_pass(k)));
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_busy"},     W'(fdr.busy),      '0);
        check({name, "_valid"},    W'(fdr.ref_valid), '0);
        check({name, "_done"},     W'(fdr.done),      '0);
        check({name, "_col_done"}, W'(fdr.col_done),  '0);
        check({name, "_pass_err"}, W'(fdr.pass_err),  '0);
        check({name, "_ref_row"},  fdr.ref_row,       '0);
        check({name, "_col_idx"},  W'(fdr.col_idx),   '0);
        check({name, "_pass_id"},  W'(fdr.pass_id),   '0);
        check({name, "_rd_en"},    W'(fdr.mem_rd_en), '0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        if (fdr.col_done) n_col_done++;
        if (fdr.done)     n_done++;
        check_outputs();
    endtask

    task automatic drive(input logic st, input logic ric, input logic chg, input logic cb);
        fdr.start             = st;
        fdr.ref_input_control = ric;
        fdr.change_ref        = chg;
        fdr.CB_select         = cb;
    endtask

    task automatic do_start();
        drive(1, 0, 0, 0); tick();
        drive(0, 0, 0, 0); repeat (3) tick();
    endtask

    bit inject_pending;
    int bad_k;

    task automatic rand_feed();
        int r;
        logic cb;
        if ($urandom_range(0, 2) != 0) begin
            cb = exp_cb();
            if (inject_pending && k >= bad_k) begin
                cb = ~cb;
                inject_pending = 0;
            end
            drive(0, 1, 1, cb);
        end else begin
            r = $urandom_range(0, 2);
            drive(0, r == 1, r == 2, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        int guard;
        drive(0, 0, 0, 0);
        model_clear();
        inject_pending = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 0;

        // First fill and one step.
        do_start();
        check("valid_latency", W'(fdr.ref_valid), W'(1));
        drive(0, 1, 1, exp_cb()); tick();
        check("first_step", fdr.ref_row, tag(1));

        // Run to col 3 row 10, then abort with reset.
        guard = 0;
        while (k != 3 * COL_ROWS + 10 && guard < 5000) begin
            inject_pending = 0;
            rand_feed(); tick(); guard++;
        end
        drive(0, 0, 0, 0);
        rst = 1;
        #1;
        check_zero("rst_mid");
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
        check_zero("rst_release");
        repeat (4) tick();

        // Two back-to-back passes of column 0.
        n_col_done = 0;
        n_done     = 0;
        do_start();
        repeat (ROWS) begin drive(0, 1, 1, 1); tick(); end
        check("pass_wrap_id",  W'(fdr.pass_id), W'(1));
        check("pass_wrap_row", fdr.ref_row, tag(0));
        check("no_early_col_done", W'(n_col_done), W'(0));
        repeat (ROWS) begin drive(0, 1, 1, 0); tick(); end
        check("col1_idx", W'(fdr.col_idx), W'(1));
        check("col1_row", fdr.ref_row, tag(ROWS));
        check("col1_done_cnt", W'(n_col_done), W'(1));

        // Gated steps and start pulses while busy.
        repeat (20) begin
            drive(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end
        check("gated_hold", fdr.ref_row, tag(ROWS));

        // Rest of the search with random gaps and one bad CB_select.
        inject_pending = 1;
        bad_k = $urandom_range(COL_ROWS + 5, TOTAL - 10);
        guard = 0;
        while (m_busy && guard < 20000) begin
            rand_feed(); tick(); guard++;
        end
        drive(0, 0, 0, 0);
        tick();
        check("idle_at_end",   W'(fdr.busy),   W'(0));
        check("col_done_cnt",  W'(n_col_done), W'(NCOLS));
        check("done_cnt",      W'(n_done),     W'(1));
        check("pass_err_kept", W'(fdr.pass_err), W'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
